// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data-bus and memory-side signals of the shared-memory arbiter
interface mem_arbiter_if #(
  parameter int XLEN = 32
);
  logic            if_req_i, if_ack_o, if_err_o;
  logic [XLEN-1:0] if_addr_i, if_rdata_o;
  logic            d_req_i, d_sel_i, d_wen_i, d_ack_o, d_err_o;
  logic [XLEN-1:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic            mem_req_o, mem_wen_o, mem_ack_i;
  logic [XLEN-1:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  modport master (
    input  if_req_i, if_addr_i, d_req_i, d_sel_i, d_addr_i, d_wdata_i, d_wen_i, mem_ack_i, mem_rdata_i,
    output if_ack_o, if_rdata_o, if_err_o, d_ack_o, d_rdata_o, d_err_o, mem_req_o, mem_addr_o, mem_wdata_o, mem_wen_o
  );
  modport slave (
    output if_req_i, if_addr_i, d_req_i, d_sel_i, d_addr_i, d_wdata_i, d_wen_i, mem_ack_i, mem_rdata_i,
    input  if_ack_o, if_rdata_o, if_err_o, d_ack_o, d_rdata_o, d_err_o, mem_req_o, mem_addr_o, mem_wdata_o, mem_wen_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory between instruction fetch and the data bus
module mem_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_D, RESP} state_t;
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  localparam logic [7:0] TMAX = 8'(TIMEOUT);
  state_t     state, state_nx;
  logic       owner_d, err_q, d_req, pick_d, gnt, tmo, resp;
  logic [3:0] starve_cnt;
  logic [7:0] wd;
  assign d_req  = bus.d_req_i & bus.d_sel_i;
  assign pick_d = d_req && (!bus.if_req_i || starve_cnt < SMAX);
  assign gnt    = state == GNT_IF || state == GNT_D;
  assign resp   = state == RESP;
  // wd counts grant cycles; the first one is the memory's sampling cycle, so waiting starts on the second
  assign tmo    = gnt && !bus.mem_ack_i && wd == TMAX;
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // next state and handshake outputs
  always_comb begin
    state_nx = state == IDLE ? (pick_d ? GNT_D : bus.if_req_i ? GNT_IF : IDLE)
             : resp ? IDLE
             : (bus.mem_ack_i || tmo) ? RESP : state;
    bus.mem_req_o = gnt;
    bus.if_ack_o  = resp && !owner_d;
    bus.d_ack_o   = resp && owner_d;
    bus.if_err_o  = resp && !owner_d && err_q;
    bus.d_err_o   = resp && owner_d && err_q;
  end
  // grant latching, watchdog, starvation count and read-data capture
  always_ff @(posedge clk)
    if (rst) begin
      owner_d         <= 1'b0;
      err_q           <= 1'b0;
      starve_cnt      <= 4'd0;
      wd              <= 8'd0;
      bus.mem_addr_o  <= {XLEN{1'b0}};
      bus.mem_wdata_o <= {XLEN{1'b0}};
      bus.mem_wen_o   <= 1'b0;
      bus.if_rdata_o  <= {XLEN{1'b0}};
      bus.d_rdata_o   <= {XLEN{1'b0}};
    end else begin
      wd <= gnt && !bus.mem_ack_i ? wd + 8'd1 : 8'd0;
      if (state == IDLE && (pick_d || bus.if_req_i)) begin
        owner_d         <= pick_d;
        bus.mem_addr_o  <= pick_d ? bus.d_addr_i : bus.if_addr_i;
        bus.mem_wdata_o <= pick_d ? bus.d_wdata_i : {XLEN{1'b0}};
        bus.mem_wen_o   <= pick_d && bus.d_wen_i;
        starve_cnt      <= pick_d ? starve_cnt + {3'd0, bus.if_req_i && starve_cnt != 4'hf} : 4'd0;
      end
      if (gnt && (bus.mem_ack_i || tmo)) err_q <= !bus.mem_ack_i;
      if (gnt && bus.mem_ack_i && !bus.mem_wen_o && owner_d) bus.d_rdata_o <= bus.mem_rdata_i;
      if (gnt && bus.mem_ack_i && !bus.mem_wen_o && !owner_d) bus.if_rdata_o <= bus.mem_rdata_i;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus against a transaction-timeline model of the arbiter
module tb_mem_arbiter;
  localparam int XLEN = 32, SMAX = 4, TMO = 16;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  mem_arbiter_if #(.XLEN(XLEN)) bus ();
  mem_arbiter #(.XLEN(XLEN), .STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

  // memory: acks one cycle after sampling a request, can be silenced, plus an injectable stray ack
  logic [31:0] mem [16];
  logic        ack_q = 1'b0, silent = 1'b0, stray = 1'b0;
  logic [31:0] rd_q = 32'h0;
  assign bus.mem_ack_i   = ack_q | stray;
  assign bus.mem_rdata_i = rd_q;
  always @(posedge clk) begin
    ack_q <= !silent && bus.mem_req_o && !ack_q;
    if (rst) begin
      mem[1] <= 32'h11111111;
      mem[2] <= 32'h22222222;
      mem[5] <= 32'hDEADBEEF;
    end else if (!silent && bus.mem_req_o && !ack_q) begin
      rd_q <= mem[bus.mem_addr_o[3:0]];
      if (bus.mem_wen_o) mem[bus.mem_addr_o[3:0]] <= bus.mem_wdata_o;
    end
  end

  int n_chk = 0, n_fail = 0;
  bit armed = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: a grant starts a fixed timeline (2 request cycles, or TIMEOUT+1 if the memory is silent), then an ack cycle, then idle
  logic [31:0] e_ifr, e_dr, e_addr, e_wd;
  logic        e_wen, e_req, e_ifa, e_da, e_ife, e_de;
  int          left, starve;
  bit          m_d, m_tmo;
  logic [31:0] mm [16];
  always @(posedge clk) begin
    bit dq, go;
    dq = bus.d_req_i && bus.d_sel_i;
    go = 1'b0;
    if (rst) begin
      left = 0; starve = 0; e_ifr = 0; e_dr = 0; e_addr = 0; e_wd = 0;
      e_wen = 0; e_req = 0; e_ifa = 0; e_da = 0; e_ife = 0; e_de = 0;
      mm[1] = 32'h11111111; mm[2] = 32'h22222222; mm[5] = 32'hDEADBEEF;
    end else if (e_ifa || e_da) begin
      e_ifa = 0; e_da = 0; e_ife = 0; e_de = 0;
    end else if (left > 1) left--;
    else if (left == 1) begin
      left = 0; e_req = 0;
      if (!m_tmo) begin
        if (e_wen) mm[e_addr[3:0]] = e_wd;
        else if (m_d) e_dr = mm[e_addr[3:0]];
        else e_ifr = mm[e_addr[3:0]];
      end
      e_ifa = !m_d; e_da = m_d; e_ife = !m_d && m_tmo; e_de = m_d && m_tmo;
    end else if (dq && (!bus.if_req_i || starve < SMAX)) begin
      m_d = 1; go = 1;
      if (bus.if_req_i && starve < 15) starve++;
      e_addr = bus.d_addr_i; e_wd = bus.d_wdata_i; e_wen = bus.d_wen_i;
    end else if (bus.if_req_i) begin
      m_d = 0; go = 1; starve = 0;
      e_addr = bus.if_addr_i; e_wd = 0; e_wen = 0;
    end
    if (go) begin
      e_req = 1; m_tmo = silent; left = silent ? TMO + 1 : 2;
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) if (armed) begin
    chk("if_ack", 32'(bus.if_ack_o), 32'(e_ifa));
    chk("if_err", 32'(bus.if_err_o), 32'(e_ife));
    chk("if_rdata", bus.if_rdata_o, e_ifr);
    chk("d_ack", 32'(bus.d_ack_o), 32'(e_da));
    chk("d_err", 32'(bus.d_err_o), 32'(e_de));
    chk("d_rdata", bus.d_rdata_o, e_dr);
    chk("mem_req", 32'(bus.mem_req_o), 32'(e_req));
    chk("mem_addr", bus.mem_addr_o, e_addr);
    chk("mem_wdata", bus.mem_wdata_o, e_wd);
    chk("mem_wen", 32'(bus.mem_wen_o), 32'(e_wen));
  end

  // one requester access: request in an idle cycle (cycle 0), disturb inputs mid-flight, wait for the ack
  task automatic access(input bit is_d, input logic [31:0] addr, input logic [31:0] wdata, input bit wen,
                        output int lat, output int req_cycles, output bit wen_seen);
    @(negedge clk);
    if (is_d) begin
      bus.d_req_i = 1; bus.d_sel_i = 1; bus.d_addr_i = addr; bus.d_wdata_i = wdata; bus.d_wen_i = wen;
    end else begin
      bus.if_req_i = 1; bus.if_addr_i = addr;
    end
    lat = 0; req_cycles = 0; wen_seen = 0;
    do begin
      @(negedge clk);
      lat++;
      req_cycles += int'(bus.mem_req_o);
      wen_seen |= bus.mem_req_o && bus.mem_wen_o;
      if (lat == 1) begin
        bus.if_addr_i ^= 32'h1; bus.d_addr_i ^= 32'h1; bus.d_wdata_i = ~bus.d_wdata_i;
      end
    end while (!(is_d ? bus.d_ack_o : bus.if_ack_o) && lat < 200);
    bus.if_req_i = 0; bus.d_req_i = 0;
  endtask

  initial begin
    int lat, rc, acts;
    bit ws;
    logic [31:0] pat;
    bus.if_req_i = 0; bus.if_addr_i = 0; bus.d_req_i = 0; bus.d_sel_i = 0;
    bus.d_addr_i = 0; bus.d_wdata_i = 0; bus.d_wen_i = 0;
    @(negedge clk); @(negedge clk);
    armed = 1;
    chk("reset_mem_req", 32'(bus.mem_req_o), 32'h0);
    chk("reset_mem_addr", bus.mem_addr_o, 32'h0);
    chk("reset_if_rdata", bus.if_rdata_o, 32'h0);
    rst = 0;
    // IF alone
    access(0, 32'd5, 32'h0, 0, lat, rc, ws);
    chk("if_latency", 32'(lat), 32'd3);
    chk("if_req_cycles", 32'(rc), 32'd2);
    chk("if_rdata_lit", bus.if_rdata_o, 32'hDEADBEEF);
    chk("if_err_lit", 32'(bus.if_err_o), 32'h0);
    repeat (3) @(negedge clk);
    chk("if_rdata_held", bus.if_rdata_o, 32'hDEADBEEF);
    // store then load
    access(1, 32'd9, 32'h12345678, 1, lat, rc, ws);
    chk("st_latency", 32'(lat), 32'd3);
    chk("st_wen_seen", 32'(ws), 32'h1);
    access(1, 32'd9, 32'h0, 0, lat, rc, ws);
    chk("ld_rdata_lit", bus.d_rdata_o, 32'h12345678);
    // deselected data request
    @(negedge clk);
    bus.d_req_i = 1; bus.d_sel_i = 0; acts = 0;
    repeat (10) begin
      @(negedge clk);
      acts += int'(bus.d_ack_o) + int'(bus.if_ack_o) + int'(bus.mem_req_o);
    end
    bus.d_req_i = 0;
    chk("nosel_activity", 32'(acts), 32'h0);
    // timeout
    silent = 1;
    access(0, 32'd1, 32'h0, 0, lat, rc, ws);
    chk("tmo_latency", 32'(lat), 32'(TMO + 2));
    chk("tmo_err", 32'(bus.if_err_o), 32'h1);
    chk("tmo_rdata_kept", bus.if_rdata_o, 32'hDEADBEEF);
    silent = 0;
    @(negedge clk);
    chk("tmo_idle", 32'(bus.mem_req_o), 32'h0);
    // contention: both held high, record ack owners (D=1, IF=0)
    @(negedge clk);
    bus.if_req_i = 1; bus.if_addr_i = 32'd1;
    bus.d_req_i = 1; bus.d_sel_i = 1; bus.d_wen_i = 0; bus.d_addr_i = 32'd2;
    pat = 0; acts = 0;
    for (int c = 0; c < 80 && acts < 10; c++) begin
      @(negedge clk);
      if (bus.d_ack_o || bus.if_ack_o) begin
        pat = {pat[30:0], bus.d_ack_o};
        acts++;
      end
    end
    bus.if_req_i = 0; bus.d_req_i = 0;
    chk("grant_pattern", pat, 32'h3DE);
    chk("cont_d_rdata", bus.d_rdata_o, 32'h22222222);
    chk("cont_if_rdata", bus.if_rdata_o, 32'h11111111);
    // reset mid-access with the memory ack landing just after reset
    @(negedge clk);
    bus.d_req_i = 1; bus.d_sel_i = 1; bus.d_wen_i = 0; bus.d_addr_i = 32'd2;
    @(negedge clk);
    chk("rst_in_grant", 32'(bus.mem_req_o), 32'h1);
    rst = 1; bus.d_req_i = 0;
    @(negedge clk);
    rst = 0;
    chk("rst_late_ack_present", 32'(bus.mem_ack_i), 32'h1);
    chk("rst_d_ack", 32'(bus.d_ack_o), 32'h0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
    chk("rst_d_rdata", bus.d_rdata_o, 32'h0);
    @(negedge clk);
    chk("rst_no_late_ack", 32'(bus.d_ack_o), 32'h0);
    access(0, 32'd5, 32'h0, 0, lat, rc, ws);
    chk("post_rst_latency", 32'(lat), 32'd3);
    chk("post_rst_rdata", bus.if_rdata_o, 32'hDEADBEEF);
    // stray ack in idle
    @(negedge clk);
    stray = 1; acts = 0;
    repeat (4) begin
      @(negedge clk);
      stray = 0;
      acts += int'(bus.d_ack_o) + int'(bus.if_ack_o) + int'(bus.mem_req_o);
    end
    chk("stray_activity", 32'(acts), 32'h0);
    access(0, 32'd5, 32'h0, 0, lat, rc, ws);
    chk("post_stray_latency", 32'(lat), 32'd3);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
